// File: rtl/mesi_isc_mem_ctrl.sv
// Main-memory controller for the four MESI ISC main-bus ports: round-robin
// arbitration, fixed-latency access sequencing and a one-cycle ack per transaction.
module mesi_isc_mem_ctrl #(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 10,
    parameter int MEM_LAT        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd3,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd2,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd1,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd0,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr3,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr2,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr1,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr0,
    input  logic [DATA_WIDTH-1:0]     mbus_data_wr3,
    input  logic [DATA_WIDTH-1:0]     mbus_data_wr2,
    input  logic [DATA_WIDTH-1:0]     mbus_data_wr1,
    input  logic [DATA_WIDTH-1:0]     mbus_data_wr0,
    output logic [DATA_WIDTH-1:0]     mbus_data_rd,
    output logic [3:0]                mbus_ack,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic                      err_addr
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD = MBUS_CMD_WIDTH'(2);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [1:0]              last_q, last_d;
    logic [1:0]              grant_q, grant_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [MEM_DEPTH];

    logic [MBUS_CMD_WIDTH-1:0] cmd_a  [4];
    logic [ADDR_WIDTH-1:0]     addr_a [4];
    logic [DATA_WIDTH-1:0]     data_a [4];
    logic [3:0]                req;
    logic                      req_any;
    logic [1:0]                pick;
    logic [1:0]                cand;
    logic                      in_range;
    logic [IDX_W-1:0]          idx;
    logic                      access_done;

    assign cmd_a[0]  = mbus_cmd0;
    assign cmd_a[1]  = mbus_cmd1;
    assign cmd_a[2]  = mbus_cmd2;
    assign cmd_a[3]  = mbus_cmd3;
    assign addr_a[0] = mbus_addr0;
    assign addr_a[1] = mbus_addr1;
    assign addr_a[2] = mbus_addr2;
    assign addr_a[3] = mbus_addr3;
    assign data_a[0] = mbus_data_wr0;
    assign data_a[1] = mbus_data_wr1;
    assign data_a[2] = mbus_data_wr2;
    assign data_a[3] = mbus_data_wr3;

    assign in_range    = addr_q < ADDR_WIDTH'(MEM_DEPTH);
    assign idx         = addr_q[IDX_W-1:0];
    assign access_done = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

    // Round-robin: scan downward so the port nearest after last_q wins; last_q itself is lowest.
    always_comb begin
        cand = 2'd0;
        pick = last_q;
        for (int i = 0; i < 4; i++) begin
            req[i] = (cmd_a[i] == CMD_WR) || (cmd_a[i] == CMD_RD);
        end
        req_any = |req;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) pick = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 2'd3;
            grant_q <= 2'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(MEM_LAT - 1);
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) state_d = ST_ACK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant latches the winner's request; the memory effect lands on the ACCESS->ACK edge.
    always_comb begin
        last_d  = last_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        err_d   = err_q;
        mem_d   = mem_q;
        if ((state_q == ST_IDLE) && req_any) begin
            grant_d = pick;
            last_d  = pick;
            wr_d    = (cmd_a[pick] == CMD_WR);
            addr_d  = addr_a[pick];
            data_d  = data_a[pick];
        end
        if (access_done) begin
            if (!in_range) begin
                err_d = 1'b1;
                if (!wr_q) rd_d = '0;
            end else if (wr_q) begin
                mem_d[idx] = data_q;
            end else begin
                rd_d = mem_q[idx];
            end
        end
    end

    always_comb begin
        mbus_ack = 4'b0000;
        if (state_q == ST_ACK) mbus_ack[grant_q] = 1'b1;
        busy = (state_q != ST_IDLE);
    end

    assign grant_id     = grant_q;
    assign mbus_data_rd = rd_q;
    assign err_addr     = err_q;

endmodule
